// File: rtl/int_issue_queue_if.sv
// Dispatch, CDB snoop and CDB result handshake bundle for the integer issue queue.
// master = dispatch/CDB side, slave = issue queue.
interface int_issue_queue_if #(
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
);
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_aluop;
  logic [TAG_W-1:0] disp_dest;
  logic             disp_v1;
  logic [XLEN-1:0]  disp_src1;
  logic             disp_v2;
  logic [XLEN-1:0]  disp_src2;
  logic             cdb_in_valid;
  logic [TAG_W-1:0] cdb_in_tag;
  logic [XLEN-1:0]  cdb_in_data;
  logic             cdb_out_valid;
  logic             cdb_out_ready;
  logic [TAG_W-1:0] cdb_out_tag;
  logic [XLEN-1:0]  cdb_out_data;

  modport master (
    output disp_valid, disp_aluop, disp_dest, disp_v1, disp_src1, disp_v2, disp_src2,
    output cdb_in_valid, cdb_in_tag, cdb_in_data, cdb_out_ready,
    input  disp_ready, cdb_out_valid, cdb_out_tag, cdb_out_data
  );

  modport slave (
    input  disp_valid, disp_aluop, disp_dest, disp_v1, disp_src1, disp_v2, disp_src2,
    input  cdb_in_valid, cdb_in_tag, cdb_in_data, cdb_out_ready,
    output disp_ready, cdb_out_valid, cdb_out_tag, cdb_out_data
  );
endinterface

// File: rtl/int_issue_queue.sv
// Integer reservation station + ALU: CDB wakeup, oldest-ready issue, 1-cycle issue to CDB output reg.
// Op ready at edge E0 appears on cdb_out after E1; output held while !cdb_out_ready, dispatch stalls when full.
module int_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  int_issue_queue_if.slave           io,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SH_W  = $clog2(XLEN);

  typedef struct packed {
    logic [3:0]       aluop;
    logic [TAG_W-1:0] dest;
    logic             v1;
    logic [XLEN-1:0]  src1;
    logic             v2;
    logic [XLEN-1:0]  src2;
  } entry_t;

  entry_t           ent   [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];  // older[i][j]: entry i was written before entry j
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] oldest;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             sel_vld;
  logic             issue;
  logic             accept;
  logic             hit1;
  logic             hit2;
  entry_t           sel;
  entry_t           new_ent;
  logic [XLEN-1:0]  alu;
  logic [SH_W-1:0]  sh;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_data;

  assign io.disp_ready    = !(&busy);
  assign io.cdb_out_valid = out_valid;
  assign io.cdb_out_tag   = out_tag;
  assign io.cdb_out_data  = out_data;

  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) rdy[i] = busy[i] & ent[i].v1 & ent[i].v2;
  end

  // A ready entry is oldest when no other ready entry is older than it.
  always_comb begin
    oldest  = rdy;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && rdy[j] && older[j][i]) oldest[i] = 1'b0;
      end
      if (oldest[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign issue  = sel_vld && (!out_valid || io.cdb_out_ready);
  assign accept = io.disp_valid && io.disp_ready && !flush;
  assign sel    = ent[sel_idx];
  assign sh     = sel.src2[SH_W-1:0];

  always_comb begin
    case (sel.aluop)
      4'b0000: alu = sel.src1 + sel.src2;
      4'b0001: alu = sel.src1 - sel.src2;
      4'b0010: alu = sel.src1 << sh;
      4'b0100: alu = {{(XLEN-1){1'b0}}, $signed(sel.src1) < $signed(sel.src2)};
      4'b0110: alu = {{(XLEN-1){1'b0}}, sel.src1 < sel.src2};
      4'b1000: alu = sel.src1 ^ sel.src2;
      4'b1010: alu = sel.src1 >> sh;
      4'b1011: alu = $unsigned($signed(sel.src1) >>> sh);
      4'b1100: alu = sel.src1 | sel.src2;
      4'b1110: alu = sel.src1 & sel.src2;
      default: alu = '0;
    endcase
  end

  // Dispatch-time bypass of a tag broadcast in the same cycle.
  assign hit1 = io.cdb_in_valid && !io.disp_v1 && (io.disp_src1[TAG_W-1:0] == io.cdb_in_tag);
  assign hit2 = io.cdb_in_valid && !io.disp_v2 && (io.disp_src2[TAG_W-1:0] == io.cdb_in_tag);

  always_comb begin
    new_ent.aluop = io.disp_aluop;
    new_ent.dest  = io.disp_dest;
    new_ent.v1    = io.disp_v1 | hit1;
    new_ent.src1  = hit1 ? io.cdb_in_data : io.disp_src1;
    new_ent.v2    = io.disp_v2 | hit2;
    new_ent.src2  = hit2 ? io.cdb_in_data : io.disp_src2;
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(busy[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]   <= '0;
        older[i] <= '0;
      end
    end else if (flush) begin
      busy      <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && io.cdb_in_valid) begin
          if (!ent[i].v1 && ent[i].src1[TAG_W-1:0] == io.cdb_in_tag) begin
            ent[i].v1   <= 1'b1;
            ent[i].src1 <= io.cdb_in_data;
          end
          if (!ent[i].v2 && ent[i].src2[TAG_W-1:0] == io.cdb_in_tag) begin
            ent[i].v2   <= 1'b1;
            ent[i].src2 <= io.cdb_in_data;
          end
        end
      end
      if (issue) begin
        busy[sel_idx] <= 1'b0;
        out_valid     <= 1'b1;
        out_tag       <= sel.dest;
        out_data      <= alu;
      end else if (io.cdb_out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        busy[free_idx] <= 1'b1;
        ent[free_idx]  <= new_ent;
        for (int j = 0; j < DEPTH; j++) begin
          older[free_idx][j] <= 1'b0;
          older[j][free_idx] <= (IDX_W'(j) != free_idx);
        end
      end
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: latency, wakeup, age-ordered select, backpressure, ALU, flush.
module tb_int_issue_queue;
  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [2:0] occupancy;
  int         tests;
  int         fails;

  int_issue_queue_if #(.TAG_W(6), .XLEN(32)) io ();

  int_issue_queue #(.DEPTH(4), .TAG_W(6), .XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .io        (io),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] dest,
                      input logic v1, input logic [31:0] s1,
                      input logic v2, input logic [31:0] s2);
    io.disp_valid = 1'b1;
    io.disp_aluop = op;
    io.disp_dest  = dest;
    io.disp_v1    = v1;
    io.disp_src1  = s1;
    io.disp_v2    = v2;
    io.disp_src2  = s2;
  endtask

  task automatic idle();
    io.disp_valid = 1'b0;
  endtask

  task automatic bcast(input logic v, input logic [5:0] tag, input logic [31:0] data);
    io.cdb_in_valid = v;
    io.cdb_in_tag   = tag;
    io.cdb_in_data  = data;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [5:0] tag,
                            input logic [31:0] data);
    check({name, "_vld"}, {31'd0, io.cdb_out_valid}, {31'd0, v});
    if (v) begin
      check({name, "_tag"}, {26'd0, io.cdb_out_tag}, {26'd0, tag});
      check({name, "_dat"}, io.cdb_out_data, data);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] dest, input logic [31:0] exp);
    disp(op, dest, 1'b1, a, 1'b1, b);
    tick();
    idle();
    tick();
    expect_out(name, 1'b1, dest, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b1;
    flush   = 1'b0;
    io.disp_valid    = 1'b0;
    io.disp_aluop    = '0;
    io.disp_dest     = '0;
    io.disp_v1       = 1'b0;
    io.disp_src1     = '0;
    io.disp_v2       = 1'b0;
    io.disp_src2     = '0;
    io.cdb_in_valid  = 1'b0;
    io.cdb_in_tag    = '0;
    io.cdb_in_data   = '0;
    io.cdb_out_ready = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_vld", {31'd0, io.cdb_out_valid}, 32'd0);
    check("rst_tag", {26'd0, io.cdb_out_tag}, 32'd0);
    check("rst_dat", io.cdb_out_data, 32'd0);
    check("rst_occ", {29'd0, occupancy}, 32'd0);
    check("rst_rdy", {31'd0, io.disp_ready}, 32'd1);
    reset_n = 1'b1;
    tick();

    // 1: ADD 5+7 -> tag 3, data 12 after two edges
    disp(4'b0000, 6'd3, 1'b1, 32'd5, 1'b1, 32'd7);
    tick();
    idle();
    expect_out("t1_e0", 1'b0, 6'd0, 32'd0);
    check("t1_occ1", {29'd0, occupancy}, 32'd1);
    tick();
    expect_out("t1_e1", 1'b1, 6'd3, 32'd12);
    check("t1_occ0", {29'd0, occupancy}, 32'd0);
    tick();
    expect_out("t1_drain", 1'b0, 6'd0, 32'd0);

    // 2: fill with src1 pending on tag 9, wake all, issue in dispatch order
    for (int k = 0; k < 4; k++) begin
      disp(4'b0000, 6'(10 + k), 1'b0, 32'd9, 1'b1, 32'(10 * (k + 1)));
      tick();
    end
    idle();
    check("t2_full_rdy", {31'd0, io.disp_ready}, 32'd0);
    check("t2_full_occ", {29'd0, occupancy}, 32'd4);
    expect_out("t2_wait", 1'b0, 6'd0, 32'd0);
    bcast(1'b1, 6'd9, 32'd1);
    tick();
    bcast(1'b0, 6'd0, 32'd0);
    expect_out("t2_wake", 1'b0, 6'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out($sformatf("t2_iss%0d", k), 1'b1, 6'(10 + k), 32'(10 * (k + 1) + 1));
      check($sformatf("t2_occ%0d", k), {29'd0, occupancy}, 32'(3 - k));
    end
    tick();
    expect_out("t2_drain", 1'b0, 6'd0, 32'd0);

    // 3: older waits on tag 5, younger ready issues first
    disp(4'b0000, 6'd20, 1'b0, 32'd5, 1'b1, 32'd100);
    tick();
    disp(4'b0001, 6'd21, 1'b1, 32'd50, 1'b1, 32'd8);
    tick();
    idle();
    tick();
    expect_out("t3_young", 1'b1, 6'd21, 32'd42);
    bcast(1'b1, 6'd5, 32'd3);
    tick();
    bcast(1'b0, 6'd0, 32'd0);
    expect_out("t3_wake", 1'b0, 6'd0, 32'd0);
    tick();
    expect_out("t3_old", 1'b1, 6'd20, 32'd103);

    // 3b: age beats index: older entry sits in a higher slot than the younger one
    disp(4'b0000, 6'd30, 1'b1, 32'd1, 1'b1, 32'd1);
    tick();
    disp(4'b0000, 6'd31, 1'b0, 32'd7, 1'b1, 32'd5);
    tick();
    expect_out("t3b_x", 1'b1, 6'd30, 32'd2);
    disp(4'b0000, 6'd32, 1'b0, 32'd7, 1'b1, 32'd6);
    tick();
    idle();
    check("t3b_occ", {29'd0, occupancy}, 32'd2);
    bcast(1'b1, 6'd7, 32'd100);
    tick();
    bcast(1'b0, 6'd0, 32'd0);
    tick();
    expect_out("t3b_y", 1'b1, 6'd31, 32'd105);
    tick();
    expect_out("t3b_z", 1'b1, 6'd32, 32'd106);
    tick();
    expect_out("t3b_drain", 1'b0, 6'd0, 32'd0);

    // same-cycle dispatch bypass of a CDB broadcast
    disp(4'b0000, 6'd33, 1'b0, 32'd8, 1'b1, 32'd3);
    bcast(1'b1, 6'd8, 32'd77);
    tick();
    idle();
    bcast(1'b0, 6'd0, 32'd0);
    tick();
    expect_out("byp", 1'b1, 6'd33, 32'd80);
    tick();

    // 4: output backpressure for 3 cycles with 2 ready ops
    io.cdb_out_ready = 1'b0;
    disp(4'b0000, 6'd40, 1'b1, 32'd2, 1'b1, 32'd3);
    tick();
    disp(4'b1000, 6'd41, 1'b1, 32'h0000_00F0, 1'b1, 32'h0000_000F);
    tick();
    idle();
    expect_out("t4_first", 1'b1, 6'd40, 32'd5);
    check("t4_occ", {29'd0, occupancy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("t4_hold%0d", k), 1'b1, 6'd40, 32'd5);
      check($sformatf("t4_hocc%0d", k), {29'd0, occupancy}, 32'd1);
    end
    io.cdb_out_ready = 1'b1;
    tick();
    expect_out("t4_second", 1'b1, 6'd41, 32'h0000_00FF);
    check("t4_occ0", {29'd0, occupancy}, 32'd0);
    tick();
    expect_out("t4_drain", 1'b0, 6'd0, 32'd0);

    // 5: ALU corner cases
    run_op("sra",  4'b1011, 32'h8000_0000, 32'd4, 6'd50, 32'hF800_0000);
    run_op("srl",  4'b1010, 32'h8000_0000, 32'd4, 6'd51, 32'h0800_0000);
    run_op("slt",  4'b0100, 32'hFFFF_FFFF, 32'd1, 6'd52, 32'd1);
    run_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'd1, 6'd53, 32'd0);
    run_op("sub",  4'b0001, 32'd0,         32'd1, 6'd54, 32'hFFFF_FFFF);
    run_op("addw", 4'b0000, 32'hFFFF_FFFF, 32'd2, 6'd55, 32'd1);
    run_op("sll",  4'b0010, 32'd3,         32'd33, 6'd56, 32'd6);
    run_op("and",  4'b1110, 32'h0000_F0F0, 32'h0000_FF00, 6'd57, 32'h0000_F000);
    run_op("or",   4'b1100, 32'h0000_F0F0, 32'h0000_FF00, 6'd58, 32'h0000_FFF0);
    run_op("bad",  4'b0011, 32'd9,         32'd9, 6'd59, 32'd0);
    tick();

    // 6: flush with 3 busy entries and a held output; flush-cycle dispatch dropped
    io.cdb_out_ready = 1'b0;
    disp(4'b0000, 6'd1, 1'b1, 32'd1, 1'b1, 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      disp(4'b0000, 6'(2 + k), 1'b0, 32'd60, 1'b1, 32'd0);
      tick();
    end
    idle();
    check("t6_occ3", {29'd0, occupancy}, 32'd3);
    expect_out("t6_held", 1'b1, 6'd1, 32'd2);
    flush = 1'b1;
    disp(4'b0000, 6'd9, 1'b1, 32'd1, 1'b1, 32'd1);
    tick();
    flush = 1'b0;
    idle();
    check("t6_occ0", {29'd0, occupancy}, 32'd0);
    expect_out("t6_flush", 1'b0, 6'd0, 32'd0);
    check("t6_rdy", {31'd0, io.disp_ready}, 32'd1);
    io.cdb_out_ready = 1'b1;
    tick();
    tick();
    expect_out("t6_dropped", 1'b0, 6'd0, 32'd0);
    check("t6_occ_after", {29'd0, occupancy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
